// File: rtl/dc_difference_decoder.sv
// rtl/dc_difference_decoder.sv - DC difference decoder with output FIFO; optional clamping via DC_DEC_SAT_EN
module dc_difference_decoder #(
    parameter int DEPTH      = 4,
    parameter int ROW_BLOCKS = 80
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        i_pd,
    output logic        o_rdy,
    input  logic [12:0] diff0,
    input  logic [13:0] dS6,
    input  logic        i_DC5,
    output logic        o_dv,
    input  logic        i_rdy,
    output logic [11:0] DC1,
    output logic        o_last,
    output logic        o_ovf
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int BW = (ROW_BLOCKS > 1) ? $clog2(ROW_BLOCKS) : 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [BW-1:0] BLK_LAST = BW'(ROW_BLOCKS - 1);

    typedef enum logic [1:0] {
        BUF_EMPTY,
        BUF_PARTIAL,
        BUF_FULL
    } buf_state_e;

    buf_state_e  state_q, state_d;
    logic [13:0] pred_q, pred_d;
    logic [BW-1:0] blk_q, blk_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic        ovf_q, ovf_d;
    logic [12:0] mem_q [DEPTH];
    logic [12:0] mem_d [DEPTH];

    logic [13:0] sum;
    logic        sum_neg;
    logic        sum_high;
    logic [11:0] dc_val;
    logic        push;
    logic        pop;
    logic        blk_is_last;

    // Handshakes come only from registered buffer state, so ready has no path from i_rdy.
    assign o_rdy  = rst_n & (state_q != BUF_FULL);
    assign o_dv   = (state_q != BUF_EMPTY);
    assign push   = i_pd & o_rdy;
    assign pop    = o_dv & i_rdy;
    assign DC1    = mem_q[rd_ptr_q][11:0];
    assign o_last = mem_q[rd_ptr_q][12];
    assign o_ovf  = ovf_q;
    assign blk_is_last = (blk_q == BLK_LAST);

    // Reconstruct the DC value from the difference and the predictor held before this edge.
    always_comb begin
        sum      = {diff0[12], diff0} + (pred_q >> 3);
        sum_neg  = sum[13];
        sum_high = ~sum[13] & sum[12];
`ifdef DC_DEC_SAT_EN
        if (sum_neg) begin
            dc_val = 12'd0;
        end else if (sum_high) begin
            dc_val = 12'hfff;
        end else begin
            dc_val = sum[11:0];
        end
`else
        dc_val = sum[11:0];
`endif
    end

    // Predictor load, block counter and sticky range flag.
    always_comb begin
        pred_d = pred_q;
        blk_d  = blk_q;
        ovf_d  = ovf_q;
        if (i_DC5) begin
            pred_d = dS6;
        end
        if (push) begin
            blk_d = blk_is_last ? '0 : blk_q + BW'(1);
            if (sum_neg || sum_high) begin
                ovf_d = 1'b1;
            end
        end
    end

    // FIFO storage write and pointer/occupancy bookkeeping.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = {blk_is_last, dc_val};
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Buffer occupancy state: EMPTY / PARTIAL / FULL.
    always_comb begin
        state_d = state_q;
        case (state_q)
            BUF_EMPTY: begin
                if (push) begin
                    state_d = BUF_PARTIAL;
                end
            end
            BUF_PARTIAL: begin
                if (push && !pop && (count_q == FULL_CNT - CW'(1))) begin
                    state_d = BUF_FULL;
                end else if (pop && !push && (count_q == CW'(1))) begin
                    state_d = BUF_EMPTY;
                end
            end
            BUF_FULL: begin
                if (pop) begin
                    state_d = BUF_PARTIAL;
                end
            end
            default: state_d = BUF_EMPTY;
        endcase
    end

    // State registers; reset discards FIFO contents, predictor, counter and flag.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= BUF_EMPTY;
            pred_q   <= '0;
            blk_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            pred_q   <= pred_d;
            blk_q    <= blk_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: tb/tb_dc_difference_decoder.sv
// tb/tb_dc_difference_decoder.sv - scoreboard bench for dc_difference_decoder
module tb_dc_difference_decoder;

    localparam int DEPTH      = 4;
    localparam int ROW_BLOCKS = 3;

    logic        pclk;
    logic        rst_n;
    logic        i_pd;
    logic        o_rdy;
    logic [12:0] diff0;
    logic [13:0] dS6;
    logic        i_DC5;
    logic        o_dv;
    logic        i_rdy;
    logic [11:0] DC1;
    logic        o_last;
    logic        o_ovf;

    dc_difference_decoder #(.DEPTH(DEPTH), .ROW_BLOCKS(ROW_BLOCKS)) dut (
        .pclk   (pclk),
        .rst_n  (rst_n),
        .i_pd   (i_pd),
        .o_rdy  (o_rdy),
        .diff0  (diff0),
        .dS6    (dS6),
        .i_DC5  (i_DC5),
        .o_dv   (o_dv),
        .i_rdy  (i_rdy),
        .DC1    (DC1),
        .o_last (o_last),
        .o_ovf  (o_ovf)
    );

    int total = 0;
    int bad   = 0;

    // reference model state
    int m_cnt  = 0;
    int m_pred = 0;
    int m_blk  = 0;
    bit m_ovf  = 0;
    int dut_acc = 0;
    logic [12:0] exp_q[$];

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int expected_dc(input int s);
`ifdef DC_DEC_SAT_EN
        if (s < 0) return 0;
        if (s > 4095) return 4095;
        return s;
`else
        return ((s % 4096) + 4096) % 4096;
`endif
    endfunction

    // One clock: check visible state, drive inputs, advance the model.
    task automatic step(input bit pd, input int d, input bit dc5, input int s,
                        input bit rdy, input int exp_head);
        int  sumv;
        bit  acc;
        bit  pp;
        bit  last;
        @(negedge pclk);
        chk("o_rdy", int'(o_rdy), int'(m_cnt != DEPTH));
        chk("o_dv", int'(o_dv), int'(m_cnt > 0));
        chk("o_ovf", int'(o_ovf), int'(m_ovf));
        if (exp_head >= 0) chk("head_DC1", int'(DC1), exp_head);
        if (pd && o_rdy) dut_acc++;
        i_pd  = pd;
        diff0 = 13'(d);
        i_DC5 = dc5;
        dS6   = 14'(s);
        i_rdy = rdy;
        acc = pd && (m_cnt != DEPTH);
        pp  = (m_cnt > 0) && rdy;
        if (acc) begin
            sumv = d + m_pred / 8;
            last = (m_blk == ROW_BLOCKS - 1);
            m_blk = (m_blk + 1) % ROW_BLOCKS;
            if (sumv < 0 || sumv > 4095) m_ovf = 1'b1;
            exp_q.push_back({last, 12'(expected_dc(sumv))});
        end
        m_cnt = m_cnt + int'(acc) - int'(pp);
        if (dc5) m_pred = s;
    endtask

    task automatic do_reset();
        @(negedge pclk);
        i_pd  = 1'b0;
        i_DC5 = 1'b0;
        i_rdy = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_o_dv", int'(o_dv), 0);
        chk("rst_o_ovf", int'(o_ovf), 0);
        chk("rst_o_rdy", int'(o_rdy), 0);
        chk("rst_DC1", int'(DC1), 0);
        chk("rst_o_last", int'(o_last), 0);
        m_cnt  = 0;
        m_pred = 0;
        m_blk  = 0;
        m_ovf  = 1'b0;
        exp_q.delete();
        @(negedge pclk);
        rst_n = 1'b1;
    endtask

    // Monitor: pop the scoreboard whenever the DUT completes an output handshake.
    initial begin
        logic [12:0] e;
        forever begin
            @(negedge pclk);
            #2;
            if (rst_n && o_dv && i_rdy) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL pop_unexpected: got DC1=%0d with no entry expected", DC1);
                end else begin
                    e = exp_q.pop_front();
                    chk("DC1", int'(DC1), int'(e[11:0]));
                    chk("o_last", int'(o_last), int'(e[12]));
                end
            end
        end
    end

    initial begin
        int d;
        rst_n = 1'b0;
        i_pd  = 1'b0;
        diff0 = '0;
        dS6   = '0;
        i_DC5 = 1'b0;
        i_rdy = 1'b0;
        do_reset();

        // basic
        step(0, 0, 1, 8000, 1, -1);
        step(1, 50, 0, 0, 1, -1);
        step(0, 0, 0, 0, 1, 1050);
        // same-cycle load + accept
        step(0, 0, 1, 8000, 1, -1);
        step(1, -10, 1, 16000, 1, -1);
        step(1, 0, 0, 0, 1, 990);
        step(0, 0, 0, 0, 1, 2000);
        // range
        step(0, 0, 1, 16376, 1, -1);
        step(1, 4095, 0, 0, 1, -1);
`ifdef DC_DEC_SAT_EN
        step(0, 0, 1, 0, 1, 4095);
        step(1, -1, 0, 0, 1, -1);
        step(0, 0, 0, 0, 1, 0);
`else
        step(0, 0, 1, 0, 1, 2046);
        step(1, -1, 0, 0, 1, -1);
        step(0, 0, 0, 0, 1, 4095);
`endif
        // backpressure
        do_reset();
        dut_acc = 0;
        for (int i = 0; i < 6; i++) step(1, 100 + i, 0, 0, 0, -1);
        chk("bp_accepts", dut_acc, 4);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1, -1);
        // row flag
        do_reset();
        for (int i = 0; i < 7; i++) step(1, 10 * i, 0, 0, 1, -1);
        step(0, 0, 0, 0, 1, -1);
        // reset mid-stream
        do_reset();
        step(1, 5, 0, 0, 0, -1);
        step(1, -5, 0, 0, 0, -1);
        step(1, 9, 0, 0, 0, -1);
        step(0, 0, 0, 0, 0, -1);
        do_reset();
        step(1, 7, 0, 0, 1, -1);
        step(0, 0, 0, 0, 1, 7);
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 1) == 0) d = int'($urandom_range(0, 127)) - 64;
            else d = int'($urandom_range(0, 8191)) - 4096;
            step($urandom_range(0, 3) != 0, d, $urandom_range(0, 3) == 0,
                 int'($urandom_range(0, 16383)), $urandom_range(0, 2) != 0, -1);
        end
        // drain, bounded
        for (int i = 0; i < 50 && m_cnt > 0; i++) step(0, 0, 0, 0, 1, -1);
        step(0, 0, 0, 0, 1, -1);
        #3;
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
